// File: rtl/mcu_pkg.sv
// Shared definitions for the fetch/dispatch controller and the execute FSMs it feeds:
// opcodes, the bus idle filler word and the controller state encoding.
package mcu_pkg;

  localparam logic [3:0] OP_ALUI0 = 4'h0;
  localparam logic [3:0] OP_ALUI1 = 4'h1;
  localparam logic [3:0] IDLE_OP  = 4'hF;

  // Foreign opcode for every execute FSM, so all of them fall back to st0.
  localparam logic [15:0] IDLE_WORD = {IDLE_OP, 12'h000};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_RETIRE = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

endpackage

// File: rtl/fetch_dispatch_ctrl_if.sv
// Handshake bundle between the fetch/dispatch controller, program memory,
// the execute FSMs and the run/status logic. master = controller side.
interface fetch_dispatch_ctrl_if #(
  parameter int DATA_W = 16
);

  logic              run;
  logic [DATA_W-1:0] memData;
  logic              memRdy;
  logic              done;
  logic              pcOutEN;
  logic              memRd;
  logic [DATA_W-1:0] instruction;
  logic              busy;
  logic              halted;
  logic [15:0]       instrCount;
  logic              err;

  modport master (
    input  run, memData, memRdy, done,
    output pcOutEN, memRd, instruction, busy, halted, instrCount, err
  );

  modport slave (
    output run, memData, memRdy, done,
    input  pcOutEN, memRd, instruction, busy, halted, instrCount, err
  );

endinterface

// File: rtl/fetch_dispatch_ctrl_exec_wdog.sv
// EXEC-phase watchdog: counts enabled cycles after a clear and flags the
// final allowed cycle. Only instantiated when FETCH_WDOG_EN is defined.
module exec_wdog #(
  parameter int LIMIT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // expired is high during the LIMIT-th enabled cycle, so the owner leaves
  // after exactly LIMIT cycles; the count saturates there.
  assign expired = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                   cnt_d = '0;
    else if (enable && !expired) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fetch_dispatch_ctrl.sv
// Instruction fetch/dispatch controller: fetches a word into IR, presents it to the
// execute FSMs until done, then retires with one idle-word gap. FETCH_WDOG_EN adds an EXEC watchdog.
module fetch_dispatch_ctrl
  import mcu_pkg::*;
#(
  parameter int         DATA_W      = 16,
  parameter logic [3:0] IDLE_OP     = mcu_pkg::IDLE_OP,
  parameter int         WDOG_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_dispatch_ctrl_if.master bus
);

  localparam logic [DATA_W-1:0] IDLE_W = {IDLE_OP, {(DATA_W-4){1'b0}}};

  if (DATA_W < 4)      $error("DATA_W must hold a 4-bit opcode");
  if (WDOG_CYCLES < 2) $error("WDOG_CYCLES must be at least 2");

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] instruction_q, instruction_d;
  logic [15:0]       instr_count_q, instr_count_d;
  logic              pc_out_en_q, pc_out_en_d;
  logic              mem_rd_q, mem_rd_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic              err_q, err_d;

`ifdef FETCH_WDOG_EN
  logic wdog_clear;
  logic wdog_expired;

  exec_wdog #(
    .LIMIT (WDOG_CYCLES)
  ) u_exec_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wdog_clear),
    .enable  (state_q == ST_EXEC),
    .expired (wdog_expired)
  );
`endif

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d       = state_q;
    ir_d          = ir_q;
    instr_count_d = instr_count_q;
    err_d         = err_q;
`ifdef FETCH_WDOG_EN
    wdog_clear    = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (bus.run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.memRdy) begin
          ir_d    = bus.memData;
          state_d = (bus.memData[DATA_W-1 -: 4] == IDLE_OP) ? ST_HALT : ST_EXEC;
`ifdef FETCH_WDOG_EN
          wdog_clear = 1'b1;
`endif
        end
      end
      ST_EXEC: begin
        if (bus.done) begin
          state_d       = ST_RETIRE;
          instr_count_d = instr_count_q + 16'd1;
        end
`ifdef FETCH_WDOG_EN
        // A timed-out instruction still retires and is counted.
        else if (wdog_expired) begin
          state_d       = ST_RETIRE;
          instr_count_d = instr_count_q + 16'd1;
          err_d         = 1'b1;
        end
`endif
      end
      ST_RETIRE: begin
        state_d = bus.run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Moore outputs are decoded from the next state so they are glitch-free flops.
    pc_out_en_d   = (state_d == ST_FETCH);
    mem_rd_d      = (state_d == ST_FETCH);
    busy_d        = (state_d != ST_IDLE) && (state_d != ST_HALT);
    halted_d      = (state_d == ST_HALT);
    instruction_d = (state_d == ST_EXEC) ? ir_d : IDLE_W;
  end

  // NOTE: sequential state uses non-blocking assignments only; rst wins over any
  // same-cycle event, so a done in the reset cycle is never counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ir_q          <= IDLE_W;
      instruction_q <= IDLE_W;
      instr_count_q <= '0;
      pc_out_en_q   <= 1'b0;
      mem_rd_q      <= 1'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      instruction_q <= instruction_d;
      instr_count_q <= instr_count_d;
      pc_out_en_q   <= pc_out_en_d;
      mem_rd_q      <= mem_rd_d;
      busy_q        <= busy_d;
      halted_q      <= halted_d;
      err_q         <= err_d;
    end
  end

  assign bus.pcOutEN     = pc_out_en_q;
  assign bus.memRd       = mem_rd_q;
  assign bus.instruction = instruction_q;
  assign bus.busy        = busy_q;
  assign bus.halted      = halted_q;
  assign bus.instrCount  = instr_count_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_fetch_dispatch_ctrl.sv
// Directed bench for fetch_dispatch_ctrl; the timeout scenario follows FETCH_WDOG_EN.
module tb_fetch_dispatch_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fetch_dispatch_ctrl_if #(.DATA_W(16)) bus ();

  fetch_dispatch_ctrl #(
    .DATA_W      (16),
    .IDLE_OP     (4'hF),
    .WDOG_CYCLES (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.run = 1'b0; bus.memRdy = 1'b0; bus.done = 1'b0; bus.memData = 16'h0000;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.instruction !== 16'hF000) begin bad++; $display("FAIL rst_instr got=%h exp=F000", bus.instruction); end
    total++; if ({bus.pcOutEN, bus.memRd, bus.busy, bus.halted, bus.err} !== 5'b00000) begin
      bad++; $display("FAIL rst_flags got=%b exp=00000", {bus.pcOutEN, bus.memRd, bus.busy, bus.halted, bus.err}); end
    total++; if (bus.instrCount !== 16'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", bus.instrCount); end
    // Reach EXEC, then assert rst together with done: rst must win.
    bus.run = 1'b1; bus.memRdy = 1'b1; bus.memData = 16'h0043;
    tick(); tick();
    bus.done = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; bus.done = 1'b0; bus.run = 1'b0;
    total++; if (bus.instrCount !== 16'd0) begin bad++; $display("FAIL rst_done_count got=%0d exp=0", bus.instrCount); end
    total++; if (bus.instruction !== 16'hF000 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL rst_done_state instr=%h busy=%b exp F000/0", bus.instruction, bus.busy); end
  endtask

  task automatic test_single();
    do_reset();
    bus.run = 1'b1; bus.memRdy = 1'b1; bus.memData = 16'h0043;
    tick();
    total++; if ({bus.pcOutEN, bus.memRd, bus.busy} !== 3'b111 || bus.instruction !== 16'hF000) begin
      bad++; $display("FAIL single_fetch pc/rd/busy=%b instr=%h exp 111/F000", {bus.pcOutEN, bus.memRd, bus.busy}, bus.instruction); end
    tick();
    bus.memData = 16'h0ABC;
    total++; if (bus.instruction !== 16'h0043 || bus.memRd !== 1'b0 || bus.pcOutEN !== 1'b0) begin
      bad++; $display("FAIL single_exec instr=%h rd=%b pc=%b exp 0043/0/0", bus.instruction, bus.memRd, bus.pcOutEN); end
    for (int i = 0; i < 7; i++) tick();
    total++; if (bus.instruction !== 16'h0043 || bus.instrCount !== 16'd0) begin
      bad++; $display("FAIL single_hold instr=%h count=%0d exp 0043/0", bus.instruction, bus.instrCount); end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0; bus.run = 1'b0;
    total++; if (bus.instruction !== 16'hF000 || bus.instrCount !== 16'd1 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL single_retire instr=%h count=%0d busy=%b exp F000/1/1", bus.instruction, bus.instrCount, bus.busy); end
    tick();
    total++; if (bus.busy !== 1'b0 || bus.memRd !== 1'b0 || bus.instrCount !== 16'd1) begin
      bad++; $display("FAIL single_idle busy=%b rd=%b count=%0d exp 0/0/1", bus.busy, bus.memRd, bus.instrCount); end
  endtask

  task automatic test_mem_wait();
    int high_cycles;
    do_reset();
    bus.run = 1'b1; bus.memRdy = 1'b0; bus.memData = 16'h0011;
    tick();
    high_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.pcOutEN === 1'b1 && bus.memRd === 1'b1 && bus.instruction === 16'hF000) high_cycles++;
      tick();
    end
    bus.memRdy = 1'b1; bus.memData = 16'h0022;
    if (bus.pcOutEN === 1'b1 && bus.memRd === 1'b1) high_cycles++;
    total++; if (high_cycles !== 6) begin bad++; $display("FAIL wait_req_cycles got=%0d exp=6", high_cycles); end
    tick();
    bus.memRdy = 1'b0;
    total++; if (bus.instruction !== 16'h0022 || bus.memRd !== 1'b0) begin
      bad++; $display("FAIL wait_ir instr=%h rd=%b exp 0022/0", bus.instruction, bus.memRd); end
    bus.done = 1'b1; bus.run = 1'b0;
    tick();
    bus.done = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.run = 1'b1; bus.memRdy = 1'b1; bus.memData = 16'h1042;
    tick(); tick();
    total++; if (bus.instruction !== 16'h1042) begin bad++; $display("FAIL b2b_first got=%h exp=1042", bus.instruction); end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    total++; if (bus.instruction !== 16'hF000 || bus.instrCount !== 16'd1) begin
      bad++; $display("FAIL b2b_gap instr=%h count=%0d exp F000/1", bus.instruction, bus.instrCount); end
    tick();
    total++; if (bus.memRd !== 1'b1 || bus.instruction !== 16'hF000) begin
      bad++; $display("FAIL b2b_refetch rd=%b instr=%h exp 1/F000", bus.memRd, bus.instruction); end
    tick();
    total++; if (bus.instruction !== 16'h1042) begin bad++; $display("FAIL b2b_second got=%h exp=1042", bus.instruction); end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0; bus.run = 1'b0;
    total++; if (bus.instrCount !== 16'd2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", bus.instrCount); end
    tick();
  endtask

  task automatic test_run_drop();
    int rd_seen;
    do_reset();
    bus.run = 1'b1; bus.memRdy = 1'b1; bus.memData = 16'h0143;
    tick(); tick();
    bus.run = 1'b0;
    tick(); tick(); tick();
    total++; if (bus.instruction !== 16'h0143 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL drop_exec instr=%h busy=%b exp 0143/1", bus.instruction, bus.busy); end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    total++; if (bus.instrCount !== 16'd1 || bus.busy !== 1'b1 || bus.instruction !== 16'hF000) begin
      bad++; $display("FAIL drop_retire count=%0d busy=%b instr=%h exp 1/1/F000", bus.instrCount, bus.busy, bus.instruction); end
    tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL drop_idle busy got=%b exp=0", bus.busy); end
    // done and memRdy outside their states must be ignored.
    rd_seen = 0;
    bus.done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.memRd !== 1'b0 || bus.busy !== 1'b0) rd_seen++;
    end
    bus.done = 1'b0;
    total++; if (rd_seen !== 0 || bus.instrCount !== 16'd1) begin
      bad++; $display("FAIL drop_quiet active_cycles=%0d count=%0d exp 0/1", rd_seen, bus.instrCount); end
  endtask

  task automatic test_halt();
    do_reset();
    bus.run = 1'b1; bus.memRdy = 1'b1; bus.memData = 16'hF123;
    tick(); tick();
    total++; if (bus.halted !== 1'b1 || bus.busy !== 1'b0 || bus.instruction !== 16'hF000 || bus.memRd !== 1'b0) begin
      bad++; $display("FAIL halt_enter halted=%b busy=%b instr=%h rd=%b exp 1/0/F000/0",
                      bus.halted, bus.busy, bus.instruction, bus.memRd); end
    bus.memData = 16'h0043; bus.done = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.done = 1'b0;
    total++; if (bus.halted !== 1'b1 || bus.memRd !== 1'b0 || bus.instrCount !== 16'd0) begin
      bad++; $display("FAIL halt_stick halted=%b rd=%b count=%0d exp 1/0/0", bus.halted, bus.memRd, bus.instrCount); end
    do_reset();
    total++; if (bus.halted !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL halt_reset halted=%b busy=%b exp 0/0", bus.halted, bus.busy); end
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    total++; if (bus.memRd !== 1'b1) begin bad++; $display("FAIL halt_restart rd got=%b exp=1", bus.memRd); end
  endtask

  task automatic test_exec_timeout();
    do_reset();
    bus.run = 1'b1; bus.memRdy = 1'b1; bus.memData = 16'h0055;
    tick(); tick();
    bus.run = 1'b0;
`ifdef FETCH_WDOG_EN
    for (int i = 1; i < 32; i++) tick();
    total++; if (bus.instruction !== 16'h0055 || bus.err !== 1'b0) begin
      bad++; $display("FAIL wdog_last_exec instr=%h err=%b exp 0055/0", bus.instruction, bus.err); end
    tick();
    total++; if (bus.instruction !== 16'hF000 || bus.err !== 1'b1 || bus.instrCount !== 16'd1) begin
      bad++; $display("FAIL wdog_retire instr=%h err=%b count=%0d exp F000/1/1", bus.instruction, bus.err, bus.instrCount); end
    tick(); tick();
    total++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL wdog_sticky err=%b busy=%b exp 1/0", bus.err, bus.busy); end
    do_reset();
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL wdog_clear err got=%b exp=0", bus.err); end
`else
    for (int i = 0; i < 40; i++) tick();
    total++; if (bus.instruction !== 16'h0055 || bus.err !== 1'b0 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL nowdog_wait instr=%h err=%b busy=%b exp 0055/0/1", bus.instruction, bus.err, bus.busy); end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    total++; if (bus.instrCount !== 16'd1 || bus.err !== 1'b0) begin
      bad++; $display("FAIL nowdog_retire count=%0d err=%b exp 1/0", bus.instrCount, bus.err); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_mem_wait();
    test_back_to_back();
    test_run_drop();
    test_halt();
    test_exec_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
